// File: rtl/count_sched_pkg.sv
// Shared types for the count-engine scheduler: FSM states and response error codes.
package count_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    RESP      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_START_TO = 2'b01,
    ERR_WDOG     = 2'b10
  } err_e;

endpackage

// File: rtl/count_sched_if.sv
// Requester-side request/response channel of the count-engine scheduler.
interface count_sched_if
  import count_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMER_W = 16,
  parameter int COUNT_W = 5
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*TIMER_W-1:0] req_wait;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [COUNT_W-1:0]         rsp_count;
  err_e                       rsp_err;

  modport master (
    output req_valid, req_wait, rsp_ready,
    input  req_ready, rsp_valid, rsp_count, rsp_err
  );

  modport slave (
    input  req_valid, req_wait, rsp_ready,
    output req_ready, rsp_valid, rsp_count, rsp_err
  );

endinterface

// File: rtl/count_sched_rr_arbiter.sv
// Generic round-robin arbiter: picks the first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [IW:0]   sum_s;
  logic [IW-1:0] pos_s;

  // Scan requests starting at ptr; the first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum_s     = '0;
    pos_s     = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr} + (IW + 1)'(i);
      sum_s = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
      pos_s = sum_s[IW-1:0];
      if (!any && req[pos_s]) begin
        any          = 1'b1;
        grant[pos_s] = 1'b1;
        grant_idx    = pos_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one count engine between requesters, with start-timeout
// and run-watchdog supervision and a one-hot valid/ready response back to the owner.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                TIMER_W    = 16,
  parameter int                COUNT_W    = 5,
  parameter int                START_TO   = 8,
  parameter int                WDOG_W     = 20,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'hFFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  count_sched_if.slave               bus,
  input  logic                       stop_in,
  output logic                       cnt_start,
  output logic                       cnt_flag,
  output logic [TIMER_W-1:0]         cnt_wait_timer,
  input  logic                       cnt_busy,
  input  logic [COUNT_W-1:0]         cnt_count_value,
  output logic                       sched_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int                 GID_W  = $clog2(NUM_REQ);
  localparam int                 TO_W   = $clog2(START_TO + 1);
  localparam logic [NUM_REQ-1:0] OH_ONE = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  state_e               state_r;
  logic [GID_W-1:0]     rr_ptr_r;
  logic [GID_W-1:0]     grant_id_r;
  logic                 cnt_start_r;
  logic [TIMER_W-1:0]   cnt_wait_timer_r;
  logic [TO_W-1:0]      to_cnt_r;
  logic [WDOG_W-1:0]    wdog_r;
  logic                 abort_r;
  logic                 sched_busy_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [COUNT_W-1:0]   rsp_count_r;
  err_e                 rsp_err_r;

  logic [NUM_REQ-1:0]   arb_grant_s;
  logic [GID_W-1:0]     arb_idx_s;
  logic                 arb_any_s;
  logic                 accept_s;
  logic [NUM_REQ-1:0]   req_ready_s;
  logic                 abort_s;
  logic                 flag_s;
  logic                 rsp_done_s;
  logic [TIMER_W-1:0]   sel_wait_s;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  // Accept decode, stop-flag forwarding and response handshake detect
  always_comb begin
    accept_s    = 1'b0;
    req_ready_s = '0;
    flag_s      = 1'b0;
    abort_s     = abort_r | (wdog_r == WDOG_LIMIT);
    rsp_done_s  = |(rsp_valid_r & bus.rsp_ready);
    sel_wait_s  = bus.req_wait[int'(arb_idx_s)*TIMER_W +: TIMER_W];
    if ((state_r == IDLE) && !rst && !cnt_busy && arb_any_s) begin
      accept_s    = 1'b1;
      req_ready_s = arb_grant_s;
    end else begin
      accept_s    = 1'b0;
      req_ready_s = '0;
    end
    // stop_in passes straight through so the engine sees it in the same cycle
    if ((state_r == RUN) && !rst) begin
      flag_s = stop_in | abort_s;
    end else begin
      flag_s = 1'b0;
    end
  end

  // Scheduler FSM with its timeout/watchdog counters and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      rr_ptr_r         <= '0;
      grant_id_r       <= '0;
      cnt_start_r      <= 1'b0;
      cnt_wait_timer_r <= '0;
      to_cnt_r         <= '0;
      wdog_r           <= '0;
      abort_r          <= 1'b0;
      sched_busy_r     <= 1'b0;
      rsp_valid_r      <= '0;
      rsp_count_r      <= '0;
      rsp_err_r        <= ERR_OK;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            grant_id_r       <= arb_idx_s;
            cnt_wait_timer_r <= sel_wait_s;
            cnt_start_r      <= 1'b1;
            sched_busy_r     <= 1'b1;
            state_r          <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_start_r <= 1'b0;
          to_cnt_r    <= '0;
          wdog_r      <= '0;
          abort_r     <= 1'b0;
          state_r     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (cnt_busy) begin
            state_r <= RUN;
          end else if (to_cnt_r == TO_W'(START_TO - 1)) begin
            rsp_count_r <= '0;
            rsp_err_r   <= ERR_START_TO;
            rsp_valid_r <= OH_ONE << grant_id_r;
            state_r     <= RESP;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        RUN: begin
          // Watchdog freezes at the limit; abort stays set until the response completes
          abort_r <= abort_s;
          if (!abort_s) begin
            wdog_r <= wdog_r + WDOG_W'(1);
          end
          if (!cnt_busy) begin
            rsp_count_r <= cnt_count_value;
            rsp_err_r   <= abort_s ? ERR_WDOG : ERR_OK;
            rsp_valid_r <= OH_ONE << grant_id_r;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (rsp_done_s) begin
            rsp_valid_r  <= '0;
            abort_r      <= 1'b0;
            sched_busy_r <= 1'b0;
            rr_ptr_r     <= (grant_id_r == GID_W'(NUM_REQ - 1)) ? '0 : (grant_id_r + GID_W'(1));
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_start_r  <= 1'b0;
          sched_busy_r <= 1'b0;
          rsp_valid_r  <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_count   = rsp_count_r;
  assign bus.rsp_err     = rsp_err_r;
  assign cnt_start       = cnt_start_r;
  assign cnt_flag        = flag_s;
  assign cnt_wait_timer  = cnt_wait_timer_r;
  assign sched_busy      = sched_busy_r;
  assign grant_id        = grant_id_r;

endmodule

// File: tb/tb_count_sched.sv
// Directed self-checking bench for count_sched: single request, round-robin, start timeout,
// watchdog abort, stop forwarding and synchronous reset in the middle of a run.
module tb_count_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop_in;
  logic        cnt_start;
  logic        cnt_flag;
  logic [15:0] cnt_wait_timer;
  logic        cnt_busy;
  logic [4:0]  cnt_count_value;
  logic        sched_busy;
  logic [1:0]  grant_id;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_g[5]  = '{0, 1, 2, 3, 0};
  int g;
  logic [3:0] oh;

  count_sched_if #(.NUM_REQ(4), .TIMER_W(16), .COUNT_W(5)) bus ();

  count_sched #(
    .NUM_REQ    (4),
    .TIMER_W    (16),
    .COUNT_W    (5),
    .START_TO   (8),
    .WDOG_W     (20),
    .WDOG_LIMIT (20'd50)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .stop_in         (stop_in),
    .cnt_start       (cnt_start),
    .cnt_flag        (cnt_flag),
    .cnt_wait_timer  (cnt_wait_timer),
    .cnt_busy        (cnt_busy),
    .cnt_count_value (cnt_count_value),
    .sched_busy      (sched_busy),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wait(input int idx, input logic [15:0] v);
    bus.req_wait[idx*16 +: 16] = v;
  endtask

  initial begin
    rst             = 1'b1;
    stop_in         = 1'b0;
    cnt_busy        = 1'b0;
    cnt_count_value = 5'd0;
    bus.req_valid   = 4'b0000;
    bus.req_wait    = 64'd0;
    bus.rsp_ready   = 4'b0000;
    cyc();
    cyc();

    // Reset state, including no accept while reset is held
    bus.req_valid = 4'b1111;
    settle();
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_start", cnt_start, 1'b0);
    chk("rst_sched_busy", sched_busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    chk("rst_timer", cnt_wait_timer, 16'd0);
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    cyc();

    // 1: single request from req0
    set_wait(0, 16'd10);
    bus.req_valid = 4'b0001;
    settle();
    chk("t1_ready", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = 4'b0000;
    chk("t1_start", cnt_start, 1'b1);
    chk("t1_timer", cnt_wait_timer, 16'd10);
    chk("t1_sched_busy", sched_busy, 1'b1);
    chk("t1_gid", grant_id, 2'd0);
    settle();
    chk("t1_ready_low", bus.req_ready, 4'b0000);
    cyc();
    chk("t1_start_pulse", cnt_start, 1'b0);
    cnt_busy = 1'b1;
    repeat (11) cyc();
    chk("t1_flag_run", cnt_flag, 1'b0);
    chk("t1_no_rsp", bus.rsp_valid, 4'b0000);
    chk("t1_timer_hold", cnt_wait_timer, 16'd10);
    cnt_busy        = 1'b0;
    cnt_count_value = 5'd7;
    cyc();
    chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t1_count", bus.rsp_count, 5'd7);
    chk("t1_err", bus.rsp_err, 2'b00);
    cnt_count_value = 5'd30;
    bus.rsp_ready   = 4'b1110;
    cyc();
    chk("t1_hold_valid", bus.rsp_valid, 4'b0001);
    chk("t1_hold_count", bus.rsp_count, 5'd7);
    bus.rsp_ready = 4'b0001;
    cyc();
    bus.rsp_ready = 4'b0000;
    chk("t1_done", bus.rsp_valid, 4'b0000);
    chk("t1_idle", sched_busy, 1'b0);

    // 2: all requesters held, round-robin from a fresh pointer
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_wait(0, 16'h0011);
    set_wait(1, 16'h0022);
    set_wait(2, 16'h0033);
    set_wait(3, 16'h0044);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g  = exp_g[k];
      oh = 4'b0001 << g;
      settle();
      chk("t2_ready", bus.req_ready, oh);
      cyc();
      chk("t2_gid", grant_id, g);
      chk("t2_timer", cnt_wait_timer, 16'h0011 * (g + 1));
      chk("t2_start", cnt_start, 1'b1);
      cyc();
      cnt_busy = 1'b1;
      cyc();
      cnt_busy        = 1'b0;
      cnt_count_value = 5'(g + 3);
      cyc();
      chk("t2_rsp_valid", bus.rsp_valid, oh);
      chk("t2_count", bus.rsp_count, g + 3);
      chk("t2_err", bus.rsp_err, 2'b00);
      bus.rsp_ready = ~oh;
      cyc();
      chk("t2_non_owner_ignored", bus.rsp_valid, oh);
      bus.rsp_ready = 4'b1111;
      cyc();
      bus.rsp_ready = 4'b0000;
      chk("t2_release", bus.rsp_valid, 4'b0000);
    end
    bus.req_valid = 4'b0000;

    // 3: busy never rises, pointer sits at 1
    bus.req_valid = 4'b0010;
    settle();
    chk("t3_ready", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = 4'b0000;
    chk("t3_start", cnt_start, 1'b1);
    repeat (8) cyc();
    chk("t3_wait_no_rsp", bus.rsp_valid, 4'b0000);
    chk("t3_wait_busy", sched_busy, 1'b1);
    cyc();
    chk("t3_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("t3_err", bus.rsp_err, 2'b01);
    chk("t3_count", bus.rsp_count, 5'd0);
    bus.rsp_ready = 4'b0010;
    cyc();
    bus.rsp_ready = 4'b0000;
    chk("t3_done", bus.rsp_valid, 4'b0000);

    // 4: pointer now 2, so req0 wins over req1; busy stuck high trips the watchdog
    bus.req_valid = 4'b0011;
    settle();
    chk("t4_rr_ready", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = 4'b0000;
    chk("t4_gid", grant_id, 2'd0);
    cyc();
    cnt_busy = 1'b1;
    cyc();
    chk("t4_flag_run0", cnt_flag, 1'b0);
    repeat (49) cyc();
    chk("t4_flag_run49", cnt_flag, 1'b0);
    cyc();
    chk("t4_flag_run50", cnt_flag, 1'b1);
    cyc();
    chk("t4_flag_sticky", cnt_flag, 1'b1);
    cnt_busy        = 1'b0;
    cnt_count_value = 5'd21;
    cyc();
    chk("t4_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t4_err", bus.rsp_err, 2'b10);
    chk("t4_count", bus.rsp_count, 5'd21);
    chk("t4_flag_resp", cnt_flag, 1'b0);
    bus.rsp_ready = 4'b0001;
    cyc();
    bus.rsp_ready = 4'b0000;

    // 5: stop_in forwarded combinationally during RUN
    bus.req_valid = 4'b0010;
    settle();
    chk("t5_ready", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cnt_busy = 1'b1;
    cyc();
    chk("t5_flag_clear", cnt_flag, 1'b0);
    stop_in = 1'b1;
    settle();
    chk("t5_flag_stop", cnt_flag, 1'b1);
    cyc();
    stop_in = 1'b0;
    settle();
    chk("t5_flag_release", cnt_flag, 1'b0);
    cnt_busy        = 1'b0;
    cnt_count_value = 5'd13;
    cyc();
    chk("t5_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("t5_err", bus.rsp_err, 2'b00);
    chk("t5_count", bus.rsp_count, 5'd13);
    bus.rsp_ready = 4'b0010;
    cyc();
    bus.rsp_ready = 4'b0000;

    // 6: wait_timer 0 from req2, then reset in the middle of RUN
    set_wait(2, 16'h0000);
    bus.req_valid = 4'b0100;
    settle();
    chk("t6_ready", bus.req_ready, 4'b0100);
    cyc();
    bus.req_valid = 4'b0000;
    chk("t6_timer_zero", cnt_wait_timer, 16'h0000);
    cyc();
    cnt_busy = 1'b1;
    cyc();
    stop_in = 1'b1;
    settle();
    chk("t6_flag_run", cnt_flag, 1'b1);
    rst = 1'b1;
    cyc();
    chk("t6_rst_flag", cnt_flag, 1'b0);
    chk("t6_rst_start", cnt_start, 1'b0);
    chk("t6_rst_sched_busy", sched_busy, 1'b0);
    chk("t6_rst_rsp_valid", bus.rsp_valid, 4'b0000);
    chk("t6_rst_count", bus.rsp_count, 5'd0);
    chk("t6_rst_err", bus.rsp_err, 2'b00);
    rst     = 1'b0;
    stop_in = 1'b0;
    set_wait(0, 16'hFFFF);
    bus.req_valid = 4'b0101;
    settle();
    chk("t6_busy_blocks", bus.req_ready, 4'b0000);
    cnt_busy = 1'b0;
    settle();
    chk("t6_ready_req0", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = 4'b0000;
    chk("t6_gid", grant_id, 2'd0);
    chk("t6_timer_max", cnt_wait_timer, 16'hFFFF);
    chk("t6_start", cnt_start, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
